ppu_oam_dma: RTL and testbench
==============================

Name: ppu_oam_dma

Overview:
- Sprite DMA controller for the CPU-side PPU register block.
- A CPU write to $4014 copies 256 bytes from CPU page $XX00-$XXFF into OAM, starting at the current OAMADDR.
- Halts the CPU for the copy and drives the CPU bus during it.
- Owns the single OAM write port and arbitrates between the DMA engine and register-path ($2004) writes.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.

Ports:
- i_cpu_clk  in  1  CPU clock.
- i_cpu_rstn  in  1  asynchronous active-low reset.
- i_bus_addr  in  16  CPU bus address (CPU-owned side).
- i_bus_wn  in  1  CPU write strobe, low = write.
- i_bus_wdata  in  8  CPU write data; page number on $4014 write.
- o_cpu_halt  out  1  high = CPU core frozen, bus owned by DMA.
- o_dma_addr  out  16  DMA read address, {page, idx}.
- o_dma_rd  out  1  DMA read strobe; data valid next cycle.
- i_dma_rdata  in  8  read data from CPU memory map.
- i_oam_base  in  8  current OAMADDR from register block.
- i_cfg_oam_addr  in  8  register-path OAM address.
- i_cfg_oam_we  in  1  register-path OAM write enable.
- i_cfg_oam_wdata  in  8  register-path OAM write data.
- o_oam_addr  out  8  OAM address to sprite RAM.
- o_oam_we  out  1  OAM write enable.
- o_oam_wdata  out  8  OAM write data.

Behaviour:
- Reset (asynchronous, i_cpu_rstn low):
  - State IDLE; r_page=0, r_base=0, r_idx=0, r_data=0, r_par=0.
  - o_cpu_halt=0, o_dma_rd=0, o_dma_addr=0.
  - OAM outputs in passthrough.
- Parity: r_par toggles every clock from reset.
- Trigger: in IDLE, when i_bus_addr==DMA_REG_ADDR and i_bus_wn==0 at edge E0:
  - latch r_page=i_bus_wdata, r_base=i_oam_base, r_idx=0;
  - go to HALT.
- $4014 writes outside IDLE are ignored (the CPU is halted in those states; this is a safety rule).
- States and transitions:
  - IDLE: as above.
  - HALT: one cycle for the CPU to release the bus. Next state is ALIGN if r_par==1 during this cycle, else READ (optional feature below).
  - ALIGN: one idle cycle, then READ.
  - READ: o_dma_rd=1, o_dma_addr={r_page,r_idx}; next state WRITE.
  - WRITE: o_oam_we=1, o_oam_addr=r_base+r_idx (8-bit, wraps mod 256), o_oam_wdata=i_dma_rdata. Then r_idx+=1. If r_idx==255, go to IDLE, else READ.
- o_cpu_halt=1 in every state except IDLE, registered, high from E0.
- Total halt length: 513 cycles (no ALIGN) or 514 cycles (with ALIGN).
- o_dma_addr holds its last value outside READ; o_dma_rd=0 outside READ.
- OAM port mux:
  - In IDLE, o_oam_* = i_cfg_oam_* (combinational passthrough).
  - In any other state, DMA drives the port; i_cfg_oam_we is dropped.
- After completion the OAM address sequence has wrapped back to r_base. OAMADDR itself is not modified.
- Page $20-$3F is legal. Reads hit PPU registers with normal side effects; no special casing.
- Reset mid-DMA: return to IDLE immediately; halt drops asynchronously; the partial OAM contents stay.

Optional Feature:
- Macro PPU_OAM_DMA_ALIGN_EN.
  - Defined: HALT goes to ALIGN when r_par==1 (513/514 cycles, hardware-accurate).
  - Undefined: HALT always goes to READ, no ALIGN state or r_par logic; fixed 513 cycles.

Decomposition:
- Shared package ppu_pkg holds:
  - 3-bit state encoding: IDLE=0, HALT=1, ALIGN=2, READ=3, WRITE=4;
  - constant PPU_OAMDMA_ADDR=16'h4014;
  - constant OAM_SIZE=256.
- No sub-module; the OAM mux is inline.

Test Plan:
- Memory $0200+i = i^8'hA5, i_oam_base=0, write $4014=$02 on an even-parity halt cycle -> o_cpu_halt high 513 cycles; OAM[i]=i^$A5 for all i; 256 o_oam_we pulses.
- Same with odd parity, macro defined -> halt 514 cycles. Macro undefined -> 513 cycles.
- i_oam_base=$10, page $03 -> OAM[$10]=mem[$0300], OAM[$0F]=mem[$03FF]; OAM[$00] written at idx $F0.
- IDLE cfg write addr $05 data $77 -> OAM[$05]=$77 the same cycle. Cfg write during DMA -> no extra write; DMA data is intact.
- Second $4014 write during DMA (forced) -> ignored; r_page is unchanged and the cycle count is unchanged.
- Reset asserted at idx 100 -> o_cpu_halt=0 immediately. After release the block is in IDLE, and a new DMA completes normally.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU definitions: OAM DMA state encoding, register address, OAM size.
// Imported by the PPU CPU-side blocks.
package ppu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] PPU_OAMDMA_ADDR = 16'h4014;
  localparam int          OAM_SIZE        = 256;
  localparam logic [7:0]  OAM_LAST        = 8'(OAM_SIZE - 1);

endpackage

// File: rtl/ppu_oam_dma.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR copies page {wdata,00..FF} into OAM
// starting at OAMADDR, halting the CPU (513 cycles, 514 when aligning).
// Owns the OAM write port: register-path passthrough in IDLE, DMA otherwise.
// Ports: i_cpu_clk/i_cpu_rstn clock and async active-low reset;
//   i_bus_* CPU bus snoop; o_cpu_halt CPU freeze;
//   o_dma_addr/o_dma_rd/i_dma_rdata DMA read side (data one cycle later);
//   i_oam_base OAMADDR; i_cfg_oam_* register-path write; o_oam_* OAM port.
// Macro PPU_OAM_DMA_ALIGN_EN: insert an ALIGN cycle on odd CPU parity.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = PPU_OAMDMA_ADDR
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  output logic        o_cpu_halt,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_rd,
  input  logic [7:0]  i_dma_rdata,
  input  logic [7:0]  i_oam_base,
  input  logic [7:0]  i_cfg_oam_addr,
  input  logic        i_cfg_oam_we,
  input  logic [7:0]  i_cfg_oam_wdata,
  output logic [7:0]  o_oam_addr,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_wdata
);

  dma_state_e  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        trig;

  assign trig = (i_bus_addr == DMA_REG_ADDR) && !i_bus_wn;

`ifdef PPU_OAM_DMA_ALIGN_EN
  logic par_q;

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) par_q <= 1'b0;
    else             par_q <= ~par_q;
  end
`endif

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state_q    <= S_IDLE;
      page_q     <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      dma_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      dma_addr_q <= dma_addr_d;
    end
  end

  // Halt is a pure decode of the state register, so it drops with reset.
  assign o_cpu_halt = (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    page_d      = page_q;
    base_d      = base_q;
    idx_d       = idx_q;
    data_d      = data_q;
    dma_addr_d  = dma_addr_q;
    o_dma_rd    = 1'b0;
    o_dma_addr  = dma_addr_q;
    o_oam_addr  = base_q + idx_q;
    o_oam_we    = 1'b0;
    o_oam_wdata = data_q;
    unique case (state_q)
      S_IDLE: begin
        o_oam_addr  = i_cfg_oam_addr;
        o_oam_we    = i_cfg_oam_we;
        o_oam_wdata = i_cfg_oam_wdata;
        if (trig) begin
          page_d  = i_bus_wdata;
          base_d  = i_oam_base;
          idx_d   = '0;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
`ifdef PPU_OAM_DMA_ALIGN_EN
        state_d = par_q ? S_ALIGN : S_READ;
`else
        state_d = S_READ;
`endif
      end
`ifdef PPU_OAM_DMA_ALIGN_EN
      S_ALIGN: state_d = S_READ;
`endif
      S_READ: begin
        o_dma_rd   = 1'b1;
        o_dma_addr = {page_q, idx_q};
        dma_addr_d = {page_q, idx_q};
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        o_oam_we    = 1'b1;
        o_oam_wdata = i_dma_rdata;
        data_d      = i_dma_rdata;
        idx_d       = idx_q + 8'd1;
        state_d     = (idx_q == OAM_LAST) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Bench for ppu_oam_dma: table DMAs, random DMAs, corner sequences.
// Memory, OAM and CPU parity are modelled behaviourally.
module tb_ppu_oam_dma;

`ifdef PPU_OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        halt;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  rdata;
  logic [7:0]  oam_base;
  logic [7:0]  cfg_addr;
  logic        cfg_we;
  logic [7:0]  cfg_wdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;

  always #5 clk = ~clk;

  ppu_oam_dma dut (
    .i_cpu_clk      (clk),
    .i_cpu_rstn     (rstn),
    .i_bus_addr     (bus_addr),
    .i_bus_wn       (bus_wn),
    .i_bus_wdata    (bus_wdata),
    .o_cpu_halt     (halt),
    .o_dma_addr     (dma_addr),
    .o_dma_rd       (dma_rd),
    .i_dma_rdata    (rdata),
    .i_oam_base     (oam_base),
    .i_cfg_oam_addr (cfg_addr),
    .i_cfg_oam_we   (cfg_we),
    .i_cfg_oam_wdata(cfg_wdata),
    .o_oam_addr     (oam_addr),
    .o_oam_we       (oam_we),
    .o_oam_wdata    (oam_wdata)
  );

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];
  int         wseq [0:255];
  int         wecnt = 0;
  int         cnt;
  int         ncmp = 0;
  int         nbad = 0;

  always @(posedge clk)
    if (dma_rd) rdata <= mem[dma_addr];

  always @(posedge clk)
    if (rstn && oam_we) begin
      oam[oam_addr]  <= oam_wdata;
      wseq[oam_addr] <= wecnt;
      wecnt          <= wecnt + 1;
    end

  // Edges seen since reset; its parity is the CPU parity.
  always @(posedge clk or negedge rstn)
    if (!rstn) cnt <= 0;
    else       cnt <= cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_page(input logic [7:0] pg);
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
  endtask

  task automatic check_oam(input string nm, input logic [7:0] pg,
                           input logic [7:0] bs, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (oam[8'(bs + 8'(i))] !== mem[{pg, 8'(i)}]) bad++;
    chk(nm, bad, 0);
  endtask

  // kind: 0 plain, 1 cfg write mid-DMA, 2 second trigger, 3 reset at idx 100
  task automatic run_dma(input logic [7:0] pg, input logic [7:0] bs,
                         input bit odd, input int kind,
                         output int len, output int pulses);
    int  w0;
    bit  done = 0;
    @(negedge clk);
    while (((cnt + 1) % 2) != int'(odd)) @(negedge clk);
    bus_addr  = 16'h4014;
    bus_wn    = 1'b0;
    bus_wdata = pg;
    oam_base  = bs;
    w0        = wecnt;
    @(posedge clk);
    #1;
    bus_wn   = 1'b1;
    bus_addr = 16'h0000;
    len      = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      bus_wn = 1'b1;
      if (!halt) done = 1;
      else begin
        len++;
        if (kind == 1 && c == 50) begin
          cfg_we = 1'b1; cfg_addr = 8'h05; cfg_wdata = 8'h77;
        end
        if (kind == 2 && c == 100) begin
          bus_addr = 16'h4014; bus_wn = 1'b0; bus_wdata = pg ^ 8'h01;
        end
        if (kind == 3 && (wecnt - w0) == 100) begin
          rstn = 1'b0;
          #1;
          chk("rst_halt_drop", {31'b0, halt}, 0);
          chk("rst_dma_rd", {31'b0, dma_rd}, 0);
          chk("rst_dma_addr", {16'b0, dma_addr}, 0);
          done = 1;
        end
      end
    end
    bus_addr = 16'h0000;
    if (!done) chk("dma_timeout", 1, 0);
    pulses = wecnt - w0;
  endtask

  typedef struct {
    logic [7:0] page;
    logic [7:0] base;
    bit         odd;
    int         exp_len;
    int         exp_we;
  } vec_t;

  vec_t vecs [5];
  int   len, pulses;
  logic [7:0] rp, rb;
  bit   ro;

  initial begin
    rstn = 1'b0; bus_addr = '0; bus_wn = 1'b1; bus_wdata = '0;
    oam_base = '0; cfg_addr = '0; cfg_we = 1'b0; cfg_wdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;

    vecs[0] = '{8'h02, 8'h00, 1'b0, 513, 256};
    vecs[1] = '{8'h02, 8'h00, 1'b1, ALIGN_EN ? 514 : 513, 256};
    vecs[2] = '{8'h03, 8'h10, 1'b0, 513, 256};
    vecs[3] = '{8'h21, 8'h80, 1'b1, ALIGN_EN ? 514 : 513, 256};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 513, 256};

    #12;
    chk("reset_halt", {31'b0, halt}, 0);
    chk("reset_dma_rd", {31'b0, dma_rd}, 0);
    chk("reset_dma_addr", {16'b0, dma_addr}, 0);
    @(negedge clk);
    rstn = 1'b1;

    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 8'h05; cfg_wdata = 8'h77;
    #1;
    chk("idle_pass_we", {31'b0, oam_we}, 1);
    chk("idle_pass_addr", {24'b0, oam_addr}, 32'h05);
    chk("idle_pass_data", {24'b0, oam_wdata}, 32'h77);
    @(posedge clk);
    #1;
    chk("idle_cfg_oam5", {24'b0, oam[5]}, 32'h77);
    cfg_we = 1'b0;

    foreach (vecs[k]) begin
      run_dma(vecs[k].page, vecs[k].base, vecs[k].odd, 0, len, pulses);
      chk($sformatf("v%0d_len", k), len, vecs[k].exp_len);
      chk($sformatf("v%0d_we", k), pulses, vecs[k].exp_we);
      check_oam($sformatf("v%0d_oam", k), vecs[k].page, vecs[k].base, 256);
      chk($sformatf("v%0d_addr_hold", k), {16'b0, dma_addr},
          {16'b0, vecs[k].page, 8'hFF});
      chk($sformatf("v%0d_rd_idle", k), {31'b0, dma_rd}, 0);
      if (k == 2) begin
        chk("b10_oam10", {24'b0, oam[8'h10]}, {24'b0, mem[16'h0300]});
        chk("b10_oam0f", {24'b0, oam[8'h0F]}, {24'b0, mem[16'h03FF]});
        chk("b10_oam00_idx", wseq[0] - (wecnt - 256), 32'hF0);
      end
    end

    for (int r = 0; r < 4; r++) begin
      rp = 8'($urandom); rb = 8'($urandom); ro = 1'($urandom);
      fill_page(rp);
      run_dma(rp, rb, ro, 0, len, pulses);
      chk($sformatf("rnd%0d_len", r), len, 513 + int'(ALIGN_EN & ro));
      chk($sformatf("rnd%0d_we", r), pulses, 256);
      check_oam($sformatf("rnd%0d_oam", r), rp, rb, 256);
    end

    fill_page(8'h04);
    run_dma(8'h04, 8'h00, 1'b0, 1, len, pulses);
    chk("cfg_mid_len", len, 513);
    chk("cfg_mid_we", pulses, 256);
    check_oam("cfg_mid_oam", 8'h04, 8'h00, 256);

    fill_page(8'h06);
    fill_page(8'h07);
    run_dma(8'h06, 8'h20, 1'b1, 2, len, pulses);
    chk("retrig_len", len, ALIGN_EN ? 514 : 513);
    chk("retrig_we", pulses, 256);
    check_oam("retrig_oam", 8'h06, 8'h20, 256);

    fill_page(8'h08);
    run_dma(8'h08, 8'h40, 1'b0, 3, len, pulses);
    repeat (3) @(negedge clk);
    chk("rst_hold_halt", {31'b0, halt}, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_halt", {31'b0, halt}, 0);
    check_oam("rst_partial", 8'h08, 8'h40, 100);
    fill_page(8'h09);
    run_dma(8'h09, 8'h00, 1'b1, 0, len, pulses);
    chk("post_rst_len", len, ALIGN_EN ? 514 : 513);
    chk("post_rst_we", pulses, 256);
    check_oam("post_rst_oam", 8'h09, 8'h00, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
